muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle, parametrised multiply/divide unit with architectural HI/LO registers. It replaces the combinational multiplier and 64-bit HI/LO flop in the MIPS datapath, and supports MULT, MULTU, DIV, DIVU, MTHI and MTLO. Operands come from the register-file read ports. The controller stalls on `busy` before issuing MFHI/MFLO or a new operation. One operation is in flight at a time; results appear in `hi`/`lo` after a fixed latency.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be even and ≥ 4.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; clears all state.
- `start`  in  1  launch operation; sampled only when `busy`=0.
- `op`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a`  in  WIDTH  multiplicand / dividend (rs).
- `b`  in  WIDTH  multiplier / divisor (rt).
- `hilo_we`  in  2  bit1 = MTHI, bit0 = MTLO write enable.
- `wdata`  in  WIDTH  data for MTHI/MTLO.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse: `hi`/`lo` just updated by an operation.
- `dbz`  out  1  sticky flag: last divide had `b`=0; cleared on next accepted `start`.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, FIX. `busy` = (state ≠ IDLE).
- **IDLE**
  - On `start`: latch `op`; latch magnitudes |a| and |b| (signed ops) or raw values (unsigned); latch result signs; clear iteration counter and `dbz`; go to CALC.
  - Sign rules: product sign = sign(a) XOR sign(b); quotient sign = same; remainder sign = sign(a).
- **CALC**: exactly WIDTH iterations, one per cycle. Counter counts 0..WIDTH-1, then go to FIX.
  - Multiply is radix-2 shift-add. Accumulator is 2·WIDTH bits; the multiplier LSB selects whether to add the multiplicand into the upper half; then shift right by 1, keeping the carry.
  - Divide is restoring. Shift the remainder:quotient pair left by 1, subtract the divisor from the upper half, and keep the result only if it is non-negative. The quotient bit = NOT borrow.
- **FIX**: one cycle.
  - Apply sign correction by two's-complement negation of the WIDTH-bit magnitudes.
  - Multiply: write {hi,lo} = 2·WIDTH product.
  - Divide: write lo = quotient, hi = remainder.
  - Go to IDLE. `done` is registered and goes high the cycle after the write.
- **Divide by zero** (`b`=0, DIV or DIVU): still runs full latency. Result: lo = all ones, hi = `a` (original, unsigned-extended value), `dbz`=1. Signed sign correction is not applied.
- **Overflow**: DIV with a = −2^(WIDTH−1), b = −1 gives lo = 0x8000…0 (wrap), hi = 0. No flag.
- **MULT with both operands at the minimum value**: the magnitude 2^(WIDTH−1) fits unsigned, and the product is exact.
- **MTHI/MTLO**: in IDLE, `hi`/`lo` take `wdata` on the edge for each set bit. Both bits set writes both.
- **Simultaneous events**:
  - `start` and `hilo_we` in the same IDLE cycle: `start` wins and the write is dropped.
  - `hilo_we` while `busy`: ignored.
  - `start` while `busy`: ignored, with no effect on the running operation.
- **Reset**:
  - Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `dbz`=0, state = IDLE.
  - Reset mid-operation aborts, and no partial result is written.

## Timing
- The edge that samples `start` is E0. Then:
  - `busy` is high from after E0 until after E(WIDTH+1).
  - CALC edges are E1..E(WIDTH).
  - The FIX edge is E(WIDTH+1) and updates `hi`/`lo`.
  - `done` is high from after E(WIDTH+1) until after E(WIDTH+2).
- Latency from `start` to valid `hi`/`lo` is WIDTH+1 edges (33 for WIDTH=32). The earliest next `start` is sampled at E(WIDTH+2).
- `hi`/`lo` hold their old values throughout CALC. They change only at FIX, on MTHI/MTLO, or at reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `a`, `b` and `op` need only be valid in the `start` cycle.

## Test plan
- **MULTU, unsigned maximum.** a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 after E33. `done` is high for exactly one cycle, and `busy` is high for 33 cycles.
- **MULT, mixed sign.** a=−3 (0xFFFFFFFD), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - Also a=b=0x80000000 → hi=0x40000000, lo=0.
- **DIV and DIVU.**
  - DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=100, b=7 → lo=14, hi=2.
  - DIV a=0x80000000, b=−1 → lo=0x80000000, hi=0.
- **Divide by zero.** DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234, `dbz`=1. The next accepted `start` clears `dbz`.
- **Concurrency.**
  - `start` pulsed at E5 during a busy operation: ignored, and the original result is unchanged.
  - MTHI of 0xAA while busy: ignored.
  - MTLO of 0x55 in IDLE: lo=0x55, hi unchanged.
  - `start` together with `hilo_we`=11: the write is dropped.
- **Reset mid-operation and width.**
  - Assert `reset` at E10 of a MULTU → hi=lo=0, `busy`=0, and no `done` pulse.
  - Rerun the first and third scenarios with WIDTH=8 (e.g. MULTU 0xFF·0xFF → hi=0xFE, lo=0x01), with `busy` high for 9 cycles.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if
//   Bus between the datapath controller and the multiply/divide unit.
//   master : controller side (drives start/op/a/b/hilo_we/wdata,
//            observes busy/done/dbz/hi/lo)
//   slave  : muldiv_unit side
//   Signals:
//     start   launch an operation (honoured only while busy is low)
//     op      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//     a, b    multiplicand/dividend and multiplier/divisor
//     hilo_we bit1 writes HI, bit0 writes LO from wdata
//     busy    operation in progress
//     done    one-cycle pulse after hi/lo were written by an operation
//     dbz     sticky divide-by-zero flag
//     hi, lo  architectural HI/LO registers
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       hilo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             dbz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hilo_we, wdata,
        input  busy, done, dbz, hi, lo
    );

    modport slave (
        input  start, op, a, b, hilo_we, wdata,
        output busy, done, dbz, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Multi-cycle multiply/divide unit holding the architectural HI/LO
//   registers. Radix-2 shift-add multiply and restoring divide on operand
//   magnitudes, one bit per cycle for WIDTH cycles, followed by a single
//   sign-correction/write-back cycle.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous active-high reset, clears all state
//     bus    muldiv_unit_if slave modport (start/op/a/b/hilo_we/wdata in,
//            busy/done/dbz/hi/lo out)
//   WIDTH must be even and at least 4.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          reset,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t             state_q, state_d;
    logic               is_div_q, is_div_d;
    logic               res_neg_q, res_neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               zero_q, zero_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               a_neg, b_neg, b_zero;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;
    logic [2*WIDTH-1:0] mul_step, div_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    // State and datapath registers; hi/lo/done/dbz are cleared on reset so an
    // aborted operation never leaves a partial result behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            zero_q    <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_div_q  <= is_div_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            zero_q    <= zero_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    // Next-state and datapath logic.
    // The accumulator holds {partial product, multiplier} for multiply and
    // {remainder, dividend/quotient} for divide. For a zero divisor the raw
    // dividend is loaded instead of its magnitude: subtracting zero never
    // borrows, so the quotient fills with ones and the remainder ends up as
    // the original a, which is exactly the divide-by-zero result.
    always_comb begin
        state_d   = state_q;
        is_div_d  = is_div_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        zero_d    = zero_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;

        a_neg  = bus.op[0] && bus.a[WIDTH-1];
        b_neg  = bus.op[0] && bus.b[WIDTH-1];
        a_mag  = a_neg ? -bus.a : bus.a;
        b_mag  = b_neg ? -bus.b : bus.b;
        b_zero = (bus.b == '0);

        // Shift-add step: the carry out of the upper-half add is kept as the
        // new MSB when the accumulator shifts right.
        add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        mul_step = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]}
                            : {1'b0, acc_q[2*WIDTH-1:1]};

        // Restoring step: trial-subtract from the shifted remainder, which
        // needs WIDTH+1 bits because the bit shifted out is still significant.
        sub_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
        div_step = sub_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                   : {sub_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        prod_fix = res_neg_q ? -acc_q : acc_q;
        quot_fix = (res_neg_q && !zero_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = (rem_neg_q && !zero_q) ? -acc_q[2*WIDTH-1:WIDTH]
                                          : acc_q[2*WIDTH-1:WIDTH];

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    is_div_d  = bus.op[1];
                    res_neg_d = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    zero_d    = bus.op[1] && b_zero;
                    dbz_d     = 1'b0;
                    count_d   = '0;
                    if (bus.op[1]) begin
                        opnd_d = b_mag;
                        acc_d  = {{WIDTH{1'b0}}, (b_zero ? bus.a : a_mag)};
                    end else begin
                        opnd_d = a_mag;
                        acc_d  = {{WIDTH{1'b0}}, b_mag};
                    end
                    state_d = CALC;
                end else begin
                    if (bus.hilo_we[1]) hi_d = bus.wdata;
                    if (bus.hilo_we[0]) lo_d = bus.wdata;
                end
            end
            CALC: begin
                acc_d   = is_div_q ? div_step : mul_step;
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    hi_d  = rem_fix;
                    lo_d  = quot_fix;
                    dbz_d = zero_q;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.dbz  = dbz_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
//   Scoreboard bench for muldiv_unit at WIDTH=32 and WIDTH=8. Issuing an
//   operation queues its expected hi/lo/dbz; a monitor pops and compares on
//   every done pulse. Directed checks cover reset, timing, HI/LO writes and
//   concurrency corner cases.
module tb_muldiv_unit;
    localparam int W = 32;
    localparam int N = 8;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    exp_t q32[$];
    exp_t q8[$];
    exp_t e32, e8;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(W)) bus32();
    muldiv_unit_if #(.WIDTH(N)) bus8();

    muldiv_unit #(.WIDTH(W)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    muldiv_unit #(.WIDTH(N)) dut8  (.clk(clk), .reset(reset), .bus(bus8));

    // Single comparison point; every check steps n_vec and, on mismatch, n_miss.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: each done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus32.done === 1'b1) begin
            if (q32.size() == 0) begin
                checkOutput("unexpected_done32", 32'd1, 32'd0);
            end else begin
                e32 = q32.pop_front();
                checkOutput("hi32", bus32.hi, e32.hi);
                checkOutput("lo32", bus32.lo, e32.lo);
                checkOutput("dbz32", {31'd0, bus32.dbz}, {31'd0, e32.dbz});
            end
        end
        if (reset === 1'b0 && bus8.done === 1'b1) begin
            if (q8.size() == 0) begin
                checkOutput("unexpected_done8", 32'd1, 32'd0);
            end else begin
                e8 = q8.pop_front();
                checkOutput("hi8", {24'd0, bus8.hi}, e8.hi);
                checkOutput("lo8", {24'd0, bus8.lo}, e8.lo);
                checkOutput("dbz8", {31'd0, bus8.dbz}, {31'd0, e8.dbz});
            end
        end
    end

    function automatic logic busyOf(input bit s);
        return s ? bus8.busy : bus32.busy;
    endfunction

    function automatic logic doneOf(input bit s);
        return s ? bus8.done : bus32.done;
    endfunction

    task automatic waitIdle(input bit s);
        int n = 0;
        while (busyOf(s) === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) checkOutput("idle_timeout", 32'd1, 32'd0);
    endtask

    // Issue one operation (optionally with a concurrent HI/LO write) and queue
    // its expected result. Returns at the falling edge after the start edge.
    task automatic applyStimulus(input bit s, input logic [1:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] we, input logic [31:0] wd,
                                 input logic [31:0] ehi, input logic [31:0] elo,
                                 input logic edbz);
        exp_t e;
        waitIdle(s);
        e.hi  = ehi;
        e.lo  = elo;
        e.dbz = edbz;
        if (s) begin
            bus8.start = 1'b1; bus8.op = op; bus8.a = a[7:0]; bus8.b = b[7:0];
            bus8.hilo_we = we; bus8.wdata = wd[7:0];
            q8.push_back(e);
        end else begin
            bus32.start = 1'b1; bus32.op = op; bus32.a = a; bus32.b = b;
            bus32.hilo_we = we; bus32.wdata = wd;
            q32.push_back(e);
        end
        @(negedge clk);
        if (s) begin
            bus8.start = 1'b0; bus8.hilo_we = 2'b00;
            bus8.op = ~op; bus8.a = ~a[7:0]; bus8.b = ~b[7:0];
        end else begin
            bus32.start = 1'b0; bus32.hilo_we = 2'b00;
            bus32.op = ~op; bus32.a = ~a; bus32.b = ~b;
        end
    endtask

    // Called right after applyStimulus: counts busy cycles then done width.
    task automatic measureBusy(input bit s, input int exp_busy);
        int nb = 0;
        int nd = 0;
        while (busyOf(s) === 1'b1 && nb < 100) begin
            nb++;
            @(negedge clk);
        end
        while (doneOf(s) === 1'b1 && nd < 10) begin
            nd++;
            @(negedge clk);
        end
        checkOutput(s ? "busy_cycles8" : "busy_cycles32", nb, exp_busy);
        checkOutput(s ? "done_width8" : "done_width32", nd, 1);
    endtask

    task automatic writeHiLo32(input logic [1:0] we, input logic [31:0] wd);
        waitIdle(1'b0);
        bus32.hilo_we = we;
        bus32.wdata   = wd;
        @(negedge clk);
        bus32.hilo_we = 2'b00;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int nd;
        reset = 1'b1;
        bus32.start = 1'b0; bus32.op = 2'b00; bus32.a = '0; bus32.b = '0;
        bus32.hilo_we = 2'b00; bus32.wdata = '0;
        bus8.start = 1'b0; bus8.op = 2'b00; bus8.a = '0; bus8.b = '0;
        bus8.hilo_we = 2'b00; bus8.wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        checkOutput("rst_hi", bus32.hi, 32'd0);
        checkOutput("rst_lo", bus32.lo, 32'd0);
        checkOutput("rst_busy", {31'd0, bus32.busy}, 32'd0);
        checkOutput("rst_done", {31'd0, bus32.done}, 32'd0);
        checkOutput("rst_dbz", {31'd0, bus32.dbz}, 32'd0);

        // Multiply
        applyStimulus(0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 0, 32'hFFFFFFFE, 32'h00000001, 0);
        measureBusy(0, 33);
        applyStimulus(0, 2'b01, 32'hFFFFFFFD, 32'd7, 2'b00, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        applyStimulus(0, 2'b01, 32'h80000000, 32'h80000000, 2'b00, 0, 32'h40000000, 32'h0, 0);

        // Divide
        applyStimulus(0, 2'b11, 32'hFFFFFFF9, 32'd2, 2'b00, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        applyStimulus(0, 2'b11, 32'h80000000, 32'hFFFFFFFF, 2'b00, 0, 32'h0, 32'h80000000, 0);
        applyStimulus(0, 2'b10, 32'd100, 32'd7, 2'b00, 0, 32'd2, 32'd14, 0);
        waitIdle(0);

        // MTLO keeps HI (=2 from the DIVU), then MTHI+MTLO together
        writeHiLo32(2'b01, 32'h55);
        checkOutput("mtlo_lo", bus32.lo, 32'h55);
        checkOutput("mtlo_hi", bus32.hi, 32'd2);
        writeHiLo32(2'b11, 32'h77);
        checkOutput("mthilo_hi", bus32.hi, 32'h77);
        checkOutput("mthilo_lo", bus32.lo, 32'h77);

        // Divide by zero, unsigned and signed; next start clears dbz
        applyStimulus(0, 2'b10, 32'h1234, 32'd0, 2'b00, 0, 32'h1234, 32'hFFFFFFFF, 1);
        waitIdle(0);
        checkOutput("dbz_set", {31'd0, bus32.dbz}, 32'd1);
        applyStimulus(0, 2'b11, 32'hFFFFFFF8, 32'd0, 2'b00, 0, 32'hFFFFFFF8, 32'hFFFFFFFF, 1);
        applyStimulus(0, 2'b00, 32'd3, 32'd5, 2'b00, 0, 32'd0, 32'd15, 0);
        checkOutput("dbz_clear", {31'd0, bus32.dbz}, 32'd0);
        waitIdle(0);

        // Stray start plus MTHI during CALC, hi/lo held during CALC
        applyStimulus(0, 2'b00, 32'd6, 32'd7, 2'b00, 0, 32'd0, 32'd42, 0);
        repeat (4) @(negedge clk);
        bus32.start = 1'b1; bus32.op = 2'b10; bus32.a = 32'd9; bus32.b = 32'd1;
        bus32.hilo_we = 2'b10; bus32.wdata = 32'hAA;
        @(negedge clk);
        bus32.start = 1'b0; bus32.hilo_we = 2'b00;
        checkOutput("calc_hold_hi", bus32.hi, 32'd0);
        checkOutput("calc_hold_lo", bus32.lo, 32'd15);
        waitIdle(0);
        @(negedge clk);
        checkOutput("after_busy_hi", bus32.hi, 32'd0);

        // start with hilo_we=11: write dropped
        applyStimulus(0, 2'b00, 32'd2, 32'd3, 2'b11, 32'hDEAD, 32'd0, 32'd6, 0);
        checkOutput("drop_we_lo", bus32.lo, 32'd42);
        checkOutput("drop_we_hi", bus32.hi, 32'd0);
        waitIdle(0);
        @(negedge clk);

        // Reset at E10 of a MULTU aborts with no done
        applyStimulus(0, 2'b00, 32'hFFFFFFFF, 32'd2, 2'b00, 0, 32'd1, 32'hFFFFFFFE, 0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        void'(q32.pop_back());
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_hi", bus32.hi, 32'd0);
        checkOutput("abort_lo", bus32.lo, 32'd0);
        checkOutput("abort_busy", {31'd0, bus32.busy}, 32'd0);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus32.done === 1'b1) nd++;
        end
        checkOutput("abort_no_done", nd, 0);

        // WIDTH=8 reruns
        applyStimulus(1, 2'b00, 32'hFF, 32'hFF, 2'b00, 0, 32'hFE, 32'h01, 0);
        measureBusy(1, 9);
        applyStimulus(1, 2'b01, 32'hFD, 32'h07, 2'b00, 0, 32'hFF, 32'hEB, 0);
        applyStimulus(1, 2'b11, 32'hF9, 32'h02, 2'b00, 0, 32'hFF, 32'hFD, 0);
        applyStimulus(1, 2'b10, 32'd100, 32'd7, 2'b00, 0, 32'd2, 32'd14, 0);
        applyStimulus(1, 2'b11, 32'h80, 32'hFF, 2'b00, 0, 32'h00, 32'h80, 0);
        waitIdle(1);
        repeat (3) @(negedge clk);

        checkOutput("pending32", q32.size(), 0);
        checkOutput("pending8", q8.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
